dtree_feature_loader: RTL
=========================

Name: dtree_feature_loader

Overview:
- Upstream feeder for the printed decision-tree classifier stages.
- Accepts one pendigits sample as a serial stream of 8-bit feature beats over a valid/ready handshake, one beat per feature, features 1..16 in order.
- Buffers the sample and presents it as a stable parallel feature vector, plus the isolated tree input feature X16, under a second valid/ready handshake.
- Holds the vector stable while the combinational tree evaluates, and rejects malformed frames.

Parameters:
- NUM_FEATURES, 16, features per sample (frame length in beats); minimum 2.
- FEAT_WIDTH, 8, bits per feature.
- SEL_FEATURE, 15, zero-based index of the feature driven on out_x16 (15 = X16).
- CNT_WIDTH, 16, width of the accepted-frame counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  loader can accept a beat.
- in_data  input  FEAT_WIDTH  feature value.
- in_last  input  1  marks final beat of a frame.
- out_valid  output  1  complete feature vector available.
- out_ready  input  1  classifier stage consumes vector.
- out_feats  output  NUM_FEATURES*FEAT_WIDTH  feature i at bits [i*FEAT_WIDTH +: FEAT_WIDTH].
- out_x16  output  FEAT_WIDTH  equals feature SEL_FEATURE of out_feats.
- frame_err  output  1  one-cycle pulse on a dropped malformed frame.
- frame_cnt  output  CNT_WIDTH  count of frames handed off; saturates at all-ones.

Behaviour:
- Reset values: rst=1 at a clock edge forces the following.
  - State FILL, beat index 0.
  - in_ready=1 after reset; the reset cycle itself shows 0.
  - out_valid=0, out_feats=0, out_x16=0, frame_err=0, frame_cnt=0.
  - Reset mid-frame or mid-hold discards all buffered data, with no frame_err.
- Beat transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- State FILL:
  - in_ready=1, out_valid=0.
  - Each accepted beat writes feat[idx] <= in_data and increments idx.
  - Beat with idx==NUM_FEATURES-1 and in_last=1: write the feature, go to HOLD, idx<=0. out_valid rises the cycle after this beat (latency 1).
  - Beat with idx<NUM_FEATURES-1 and in_last=1 (short frame): frame_err pulses next cycle, idx<=0, stay in FILL. Features written so far are not presented.
  - Beat with idx==NUM_FEATURES-1 and in_last=0 (long frame): frame_err pulses, go to DRAIN.
- State DRAIN:
  - in_ready=1; beats are discarded until a beat with in_last=1 is accepted, then go to FILL with idx<=0.
  - Further frame_err pulses are not generated while draining.
- State HOLD:
  - in_ready=0, out_valid=1; out_feats and out_x16 are stable and unchanged.
  - On output transfer: go to FILL, frame_cnt increments (holds if saturated), out_valid falls next cycle.
  - Register contents stay on out_feats after handoff until overwritten by new beats. Consumers must qualify with out_valid.
- Simultaneous events:
  - in_valid is ignored in HOLD.
  - out_ready is ignored when out_valid=0.
  - Back-to-back frames: the first beat of the next frame can be accepted the cycle after the output transfer, so minimum frame period is NUM_FEATURES+1 cycles.
- Arithmetic:
  - idx width is clog2(NUM_FEATURES); no wrap beyond NUM_FEATURES-1 occurs.
  - frame_cnt uses saturating add.
- out_x16 is a direct register alias, not an extra stage.

Decomposition:
- Shared package dtree_pkg holds:
  - localparams PENDIGITS_NUM_FEATURES=16 and PENDIGITS_FEAT_WIDTH=8;
  - the loader state enum {FILL, HOLD, DRAIN} as a typedef;
  - the feature vector packed-array typedef.
- No sub-module is needed; one optional helper, dtree_sat_counter (parameterised width saturating counter), is reused by later stages that count classifications.

Test Plan:
- Reset then one frame of beats 0x10..0x1F with in_last on beat 16, out_ready=1:
  - out_valid=1 exactly one cycle after the last beat, for one cycle;
  - out_x16=0x1F, out_feats[7:0]=0x10;
  - frame_cnt=1; in_ready=0 during that cycle.
- Same frame with out_ready=0 for 5 cycles, in_valid held 1 with changing data:
  - out_valid stays 1, out_feats unchanged, in_ready=0;
  - handoff occurs on the first out_ready=1 cycle.
- Short frame, in_last on beat 7:
  - frame_err one pulse, no out_valid;
  - the next full frame of 0xA0..0xAF yields out_x16=0xAF.
- Long frame of 18 beats, in_last on beat 18:
  - one frame_err pulse; beats 17 and 18 are dropped;
  - the next well-formed frame is presented correctly, and frame_cnt counts only good frames.
- rst asserted after beat 9 of a frame:
  - next cycle all outputs are at reset values, with no frame_err;
  - a following full frame works, with frame_cnt=1.
- frame_cnt with CNT_WIDTH=2, 5 good frames -> frame_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/dtree_pkg.sv
// ============================================================================
// Module   : dtree_pkg
// Brief    : Shared types and constants for the pendigits decision-tree path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dtree_pkg;

   localparam int PENDIGITS_NUM_FEATURES = 16;
   localparam int PENDIGITS_FEAT_WIDTH   = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } loader_state_e;

   typedef logic [PENDIGITS_NUM_FEATURES-1:0][PENDIGITS_FEAT_WIDTH-1:0] feat_vec_t;

endpackage

`default_nettype wire

// File: rtl/dtree_sat_counter.sv
// ============================================================================
// Module   : dtree_sat_counter
// Brief    : Parameterised up-counter that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtree_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/dtree_feature_loader.sv
// ============================================================================
// Module   : dtree_feature_loader
// Brief    : Collects a serial feature frame and holds it as a parallel vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dtree_feature_loader
   import dtree_pkg::*;
#(
   parameter int NUM_FEATURES = PENDIGITS_NUM_FEATURES,
   parameter int FEAT_WIDTH   = PENDIGITS_FEAT_WIDTH,
   parameter int SEL_FEATURE  = 15,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [FEAT_WIDTH-1:0]            in_data,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_FEATURES*FEAT_WIDTH-1:0] out_feats,
   output logic [FEAT_WIDTH-1:0]            out_x16,
   output logic                             frame_err,
   output logic [CNT_WIDTH-1:0]             frame_cnt
);

   localparam int                 c_idx_w    = $clog2(NUM_FEATURES);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_FEATURES - 1);

   loader_state_e r_state;
   loader_state_e w_state_next;

   logic [c_idx_w-1:0] r_idx;
   logic [c_idx_w-1:0] w_idx_next;

   logic [NUM_FEATURES-1:0][FEAT_WIDTH-1:0] r_feats;

   logic r_err;
   logic w_err_next;
   logic w_beat;
   logic w_write;
   logic w_handoff;

   // in_ready is gated by rst so the reset cycle itself never advertises space.
   assign in_ready  = !rst && (r_state != HOLD);
   assign out_valid = (r_state == HOLD);
   assign w_beat    = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_err_next   = 1'b0;
      w_write      = 1'b0;
      w_handoff    = 1'b0;
      case (r_state)
         FILL: begin
            if (w_beat) begin
               w_write = 1'b1;
               if (r_idx == c_last_idx) begin
                  w_idx_next   = '0;
                  w_state_next = in_last ? HOLD : DRAIN;
                  w_err_next   = !in_last;
               end else if (in_last) begin
                  w_idx_next = '0;
                  w_err_next = 1'b1;
               end else begin
                  w_idx_next = r_idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_handoff    = 1'b1;
               w_state_next = FILL;
            end
         end
         DRAIN: begin
            // Overlong frame: swallow the tail silently until its last beat.
            if (w_beat && in_last) begin
               w_state_next = FILL;
               w_idx_next   = '0;
            end
         end
         default: begin
            w_state_next = FILL;
            w_idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_err_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_feat
         always_ff @(posedge clk) begin
            if (rst) begin
               r_feats[gi] <= '0;
            end else if (w_write && (r_idx == c_idx_w'(gi))) begin
               r_feats[gi] <= in_data;
            end
         end
      end
   endgenerate

   dtree_sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_frame_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_handoff),
      .count (frame_cnt)
   );

   assign out_feats = r_feats;
   assign out_x16   = r_feats[SEL_FEATURE];
   assign frame_err = r_err;

endmodule

`default_nettype wire
